// File: rtl/clk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clk_pkg
//  Purpose  : Shared types, widths and constant helpers for the BCD clock
//             datapath stages (bcd_mod_counter and its digit stepper).
//  Contents : cnt_state_t - counter stage FSM states (IDLE, STEP, WRAP)
//             BCD_W       - width of one BCD digit
//             to_bcd()    - integer 0..99 to packed {tens, ones} BCD byte
//  Revision : 1.0 - initial release
// ============================================================================
package clk_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        WRAP = 2'd2
    } cnt_state_t;

    // Elaboration-time helper for reset and boundary constants only.
    function automatic logic [2*BCD_W-1:0] to_bcd(input int value);
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
        tens = BCD_W'(value / 10);
        ones = BCD_W'(value % 10);
        return {tens, ones};
    endfunction

endpackage : clk_pkg
`default_nettype wire

// File: rtl/bcd_digit_step.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit_step
//  Purpose  : Combinational one-step BCD increment/decrement of a tens/ones
//             pair. Range limits are handled by the caller; this block only
//             performs the digit carry/borrow between ones and tens.
//  Ports    : i_tens [TENS_W] - current tens digit
//             i_ones [4]      - current ones digit (0..9)
//             i_down          - 0 = increment, 1 = decrement
//             o_tens [TENS_W] - stepped tens digit
//             o_ones [4]      - stepped ones digit
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_step
    import clk_pkg::*;
#(
    parameter int TENS_W = 3
) (
    input  logic [TENS_W-1:0] i_tens,
    input  logic [BCD_W-1:0]  i_ones,
    input  logic              i_down,
    output logic [TENS_W-1:0] o_tens,
    output logic [BCD_W-1:0]  o_ones
);

    always_comb begin
        o_tens = i_tens;
        o_ones = i_ones;
        if (i_down) begin
            if (i_ones == BCD_W'(0)) begin
                o_ones = BCD_W'(9);
                o_tens = i_tens - TENS_W'(1);
            end else begin
                o_ones = i_ones - BCD_W'(1);
            end
        end else begin
            if (i_ones == BCD_W'(9)) begin
                o_ones = BCD_W'(0);
                o_tens = i_tens + TENS_W'(1);
            end else begin
                o_ones = i_ones + BCD_W'(1);
            end
        end
    end

endmodule : bcd_digit_step
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_mod_counter
//  Purpose  : BCD modulo counter stage (MIN_VALUE..MODULUS-1), stepped once
//             per rising edge of changeIn, up or down. Emits a one-cycle
//             carry on up-wrap and borrow on down-wrap for chaining.
//  Options  : `define BCD_MOD_COUNTER_SET_EN enables the setEn time-set load.
//             Without it setEn/setTens/setOnes are present but ignored.
//  Ports    : clkMSec            - clock, rising edge
//             resetN             - asynchronous active-low reset
//             changeIn           - advance request (edge detected)
//             countDown          - direction sampled with the event
//             setEn              - one-cycle load strobe (option only)
//             setTens [TENS_W]   - tens digit to load
//             setOnes [4]        - ones digit to load
//             carryOut           - one-cycle pulse on up-wrap
//             borrowOut          - one-cycle pulse on down-wrap
//             tensOut [TENS_W]   - BCD tens digit
//             onesOut [4]        - BCD ones digit
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_mod_counter
    import clk_pkg::*;
#(
    parameter int MODULUS   = 60,
    parameter int MIN_VALUE = 0,
    parameter int TENS_W    = 3
) (
    input  logic              clkMSec,
    input  logic              resetN,
    input  logic              changeIn,
    input  logic              countDown,
    input  logic              setEn,
    input  logic [TENS_W-1:0] setTens,
    input  logic [BCD_W-1:0]  setOnes,
    output logic              carryOut,
    output logic              borrowOut,
    output logic [TENS_W-1:0] tensOut,
    output logic [BCD_W-1:0]  onesOut
);

    localparam logic [2*BCD_W-1:0] MAX_BCD  = to_bcd(MODULUS - 1);
    localparam logic [2*BCD_W-1:0] MIN_BCD  = to_bcd(MIN_VALUE);
    localparam logic [TENS_W-1:0]  MAX_TENS = TENS_W'(MAX_BCD[2*BCD_W-1:BCD_W]);
    localparam logic [BCD_W-1:0]   MAX_ONES = MAX_BCD[BCD_W-1:0];
    localparam logic [TENS_W-1:0]  MIN_TENS = TENS_W'(MIN_BCD[2*BCD_W-1:BCD_W]);
    localparam logic [BCD_W-1:0]   MIN_ONES = MIN_BCD[BCD_W-1:0];

    cnt_state_t        state_q, state_d;
    logic              chg_q;
    logic              dir_q, dir_d;
    logic [TENS_W-1:0] tens_q, tens_d;
    logic [BCD_W-1:0]  ones_q, ones_d;
    logic              carry_q, carry_d;
    logic              borrow_q, borrow_d;

    logic              chg_evt;
    logic              at_top;
    logic              at_bottom;
    logic              at_bound;
    logic              set_take;
    logic              set_load;
    logic [TENS_W-1:0] step_tens;
    logic [BCD_W-1:0]  step_ones;

    assign chg_evt   = changeIn & ~chg_q;
    assign at_top    = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);
    assign at_bottom = (tens_q == MIN_TENS) && (ones_q == MIN_ONES);
    // Boundary is judged against the direction sampled with the event.
    assign at_bound  = countDown ? at_bottom : at_top;

`ifdef BCD_MOD_COUNTER_SET_EN
    logic [31:0] set_val;
    logic        set_valid;

    assign set_val   = 32'(setTens) * 32'd10 + 32'(setOnes);
    assign set_valid = (setOnes <= BCD_W'(9)) &&
                       (set_val >= 32'(MIN_VALUE)) &&
                       (set_val <= 32'(MODULUS - 1));
    // A strobe in IDLE swallows any same-cycle event, valid load or not.
    assign set_take  = setEn && (state_q == IDLE);
    assign set_load  = set_take && set_valid;
`else
    logic unused_set;

    assign unused_set = ^{setEn, setTens, setOnes};
    assign set_take   = 1'b0;
    assign set_load   = 1'b0;
`endif

    bcd_digit_step #(
        .TENS_W (TENS_W)
    ) u_step (
        .i_tens (tens_q),
        .i_ones (ones_q),
        .i_down (dir_q),
        .o_tens (step_tens),
        .o_ones (step_ones)
    );

    // State register plus all datapath/output flops.
    always_ff @(posedge clkMSec or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            chg_q    <= 1'b0;
            dir_q    <= 1'b0;
            tens_q   <= MIN_TENS;
            ones_q   <= MIN_ONES;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            chg_q    <= changeIn;
            dir_q    <= dir_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (chg_evt && !set_take) begin
                    state_d = at_bound ? WRAP : STEP;
                end
            end
            STEP:    state_d = IDLE;
            WRAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic.
    always_comb begin
        dir_d    = dir_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (set_load) begin
                    tens_d = setTens;
                    ones_d = setOnes;
                end else if (chg_evt && !set_take) begin
                    dir_d = countDown;
                end
            end
            STEP: begin
                tens_d = step_tens;
                ones_d = step_ones;
            end
            WRAP: begin
                if (dir_q) begin
                    tens_d   = MAX_TENS;
                    ones_d   = MAX_ONES;
                    borrow_d = 1'b1;
                end else begin
                    tens_d   = MIN_TENS;
                    ones_d   = MIN_ONES;
                    carry_d  = 1'b1;
                end
            end
            default: begin
                tens_d = MIN_TENS;
                ones_d = MIN_ONES;
            end
        endcase
    end

    assign carryOut  = carry_q;
    assign borrowOut = borrow_q;
    assign tensOut   = tens_q;
    assign onesOut   = ones_q;

endmodule : bcd_mod_counter
`default_nettype wire
